display_scan: RTL and testbench



---
 rtl/display_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 36 +++
 rtl/display_scan.sv | 131 +++++++++++++
 tb/tb_display_scan.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display scanner.
// Codes are 5 bits wide: 0x00-0x0F are hex glyphs, 0x11 is a minus sign,
// everything else renders blank. Segment vectors are {A,B,C,D,E,F,G}
// with A in bit 6, active-high.
package display_pkg;

    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;

    localparam logic [CODE_W-1:0] CODE_ZERO  = 5'h00;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'h10;
    localparam logic [CODE_W-1:0] CODE_MINUS = 5'h11;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0000001;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational 5-bit code to seven-segment decoder.
// Ports:
//   code - 5-bit display code
//   seg  - segments {A,B,C,D,E,F,G}, active-high
module seg7_decode
    import display_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'h00: seg = SEG_0;
            5'h01: seg = SEG_1;
            5'h02: seg = SEG_2;
            5'h03: seg = SEG_3;
            5'h04: seg = SEG_4;
            5'h05: seg = SEG_5;
            5'h06: seg = SEG_6;
            5'h07: seg = SEG_7;
            5'h08: seg = SEG_8;
            5'h09: seg = SEG_9;
            5'h0A: seg = SEG_A;
            5'h0B: seg = SEG_B;
            5'h0C: seg = SEG_C;
            5'h0D: seg = SEG_D;
            5'h0E: seg = SEG_E;
            5'h0F: seg = SEG_F;
            CODE_MINUS: seg = SEG_MINUS;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed seven-segment scanner with double-buffered digit codes.
// A prescaler holds each digit for REFRESH_DIV cycles; the first cycle of
// each slot is dead time (all outputs off) to suppress ghosting. Loaded
// codes wait in a pending buffer and are committed only on the last cycle
// of a frame, so a frame never shows a mix of old and new digits.
//
// Handshake: load_i is a one-cycle strobe with no back-pressure. Every
// cycle it is high, data_i is captured into the pending buffer (latest
// load wins). A load on the commit cycle itself lands in pending and does
// not take part in that cycle's commit.
//
// Optional feature macro: DISPLAY_SCAN_LZ_BLANK_EN enables leading-zero
// blanking of the active buffer (digit 0 is always shown).
//
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   data_i    - digit codes, digit k at [5k+4:5k], digit 0 rightmost
//   load_i    - capture strobe for data_i
//   seg_o     - registered segments {A..G}, active-high
//   dig_o     - registered one-hot digit select, active-high
//   pending_o - a loaded value is waiting for commit
//   frame_o   - one-cycle pulse after each frame's last cycle
module display_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CODE_W*NUM_DIGITS-1:0] data_i,
    input  logic                         load_i,
    output logic [SEG_W-1:0]             seg_o,
    output logic [NUM_DIGITS-1:0]        dig_o,
    output logic                         pending_o,
    output logic                         frame_o
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [CODE_W-1:0] active  [NUM_DIGITS];
    logic [CODE_W-1:0] pending [NUM_DIGITS];

    logic              pre_last;
    logic              commit_cycle;
    logic [CODE_W-1:0] cur_code;
    logic [SEG_W-1:0]  dec_seg;
    logic [SEG_W-1:0]  seg_next;
    logic [NUM_DIGITS-1:0] lz_mask;

    assign pre_last     = (pre == PRE_LAST);
    assign commit_cycle = pre_last && (idx == IDX_LAST);
    assign cur_code     = active[idx];

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
    // Walk down from the most significant digit; a digit is blanked while
    // every digit at or above it holds code 0. Digit 0 is never blanked.
    logic zero_run;
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (active[k] == CODE_ZERO);
            lz_mask[k] = zero_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign seg_next = lz_mask[idx] ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre       <= '0;
            idx       <= '0;
            pending_o <= 1'b0;
            frame_o   <= 1'b0;
            seg_o     <= SEG_BLANK;
            dig_o     <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                active[k]  <= CODE_BLANK;
                pending[k] <= CODE_BLANK;
            end
        end else begin
            pre <= pre_last ? '0 : pre + 1'b1;
            if (pre_last) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            frame_o <= commit_cycle;

            // Slot's first cycle is dead time so the previous digit's
            // segments never bleed into the newly selected digit.
            if (pre == '0) begin
                dig_o <= '0;
                seg_o <= SEG_BLANK;
            end else begin
                dig_o <= NUM_DIGITS'(1) << idx;
                seg_o <= seg_next;
            end

            if (commit_cycle && pending_o) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    active[k] <= pending[k];
                end
                pending_o <= 1'b0;
            end

            // Placed after the commit so a same-cycle load keeps the flag set.
            if (load_i) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    pending[k] <= data_i[k*CODE_W +: CODE_W];
                end
                pending_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

    localparam int ND  = 4;
    localparam int RD  = 4;
    localparam int FRM = ND * RD;

    logic          clk;
    logic          rst;
    logic [19:0]   data_i;
    logic          load_i;
    logic [6:0]    seg_o;
    logic [3:0]    dig_o;
    logic          pending_o;
    logic          frame_o;

    int total = 0;
    int bad   = 0;

    display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .load_i    (load_i),
        .seg_o     (seg_o),
        .dig_o     (dig_o),
        .pending_o (pending_o),
        .frame_o   (frame_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Model state: cycles since reset, display contents, pending contents.
    int         m_c;
    logic [4:0] m_active  [ND];
    logic [4:0] m_pending [ND];
    logic       m_pflag;
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic       e_pend;
    logic       e_frame;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00: return 7'h7E; 5'h01: return 7'h30; 5'h02: return 7'h6D;
            5'h03: return 7'h79; 5'h04: return 7'h33; 5'h05: return 7'h5B;
            5'h06: return 7'h5F; 5'h07: return 7'h70; 5'h08: return 7'h7F;
            5'h09: return 7'h7B; 5'h0A: return 7'h77; 5'h0B: return 7'h1F;
            5'h0C: return 7'h4E; 5'h0D: return 7'h3D; 5'h0E: return 7'h4F;
            5'h0F: return 7'h47; 5'h11: return 7'h01;
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit lz_blank(input int k);
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
        if (k == 0) return 1'b0;
        for (int j = k; j < ND; j++)
            if (m_active[j] != 5'h00) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [19:0] pack4(input logic [4:0] d3, input logic [4:0] d2,
                                          input logic [4:0] d1, input logic [4:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic model_edge(input logic r, input logic ld, input logic [19:0] d);
        int pre;
        int idx;
        if (r) begin
            m_c = 0;
            m_pflag = 1'b0;
            for (int k = 0; k < ND; k++) begin
                m_active[k]  = 5'h10;
                m_pending[k] = 5'h10;
            end
            e_seg = 0; e_dig = 0; e_frame = 0; e_pend = 0;
            return;
        end
        pre = m_c % RD;
        idx = (m_c / RD) % ND;
        if (pre == 0) begin
            e_seg = 0;
            e_dig = 0;
        end else begin
            e_dig = 4'(1 << idx);
            e_seg = lz_blank(idx) ? 7'h00 : glyph(m_active[idx]);
        end
        e_frame = (m_c % FRM) == FRM - 1;
        if (e_frame && m_pflag) begin
            for (int k = 0; k < ND; k++) m_active[k] = m_pending[k];
            m_pflag = 1'b0;
        end
        if (ld) begin
            for (int k = 0; k < ND; k++) m_pending[k] = d[k*5 +: 5];
            m_pflag = 1'b1;
        end
        e_pend = m_pflag;
        m_c++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, m_c, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drive, let the edge happen, update the model,
    // then compare at the following negedge.
    task automatic step(input logic r, input logic ld, input logic [19:0] d);
        rst = r; load_i = ld; data_i = d;
        @(posedge clk);
        model_edge(r, ld, d);
        @(negedge clk);
        check("seg", 32'(seg_o), 32'(e_seg));
        check("dig", 32'(dig_o), 32'(e_dig));
        check("pend", 32'(pending_o), 32'(e_pend));
        check("frame", 32'(frame_o), 32'(e_frame));
    endtask

    task automatic do_reset();
        repeat (3) step(1'b1, 1'b0, 20'h0);
    endtask

    task automatic run_to(input int n);
        while (m_c < n) step(1'b0, 1'b0, 20'h0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic        load;
        logic [19:0] data;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        pend;
        logic        frame;
    } vec_t;

    vec_t vecs [10];

    initial begin
        rst = 1'b1; load_i = 1'b0; data_i = '0;
        m_c = 0; m_pflag = 1'b0;
        @(negedge clk);

        vecs[0] = '{1'b1, 1'b0, 20'h0, 7'h00, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 20'h0, 7'h00, 4'b0000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 20'h0, 7'h00, 4'b0000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 20'h0, 7'h00, 4'b0000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, pack4(5'h1, 5'h2, 5'h3, 5'h4), 7'h00, 4'b0001, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 20'h0, 7'h00, 4'b0001, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 20'h0, 7'h00, 4'b0001, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 20'h0, 7'h00, 4'b0000, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 20'h0, 7'h00, 4'b0010, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 20'h0, 7'h00, 4'b0010, 1'b1, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].data);
            check("tbl_seg", 32'(seg_o), 32'(vecs[i].seg));
            check("tbl_dig", 32'(dig_o), 32'(vecs[i].dig));
            check("tbl_pend", 32'(pending_o), 32'(vecs[i].pend));
            check("tbl_frame", 32'(frame_o), 32'(vecs[i].frame));
        end

        // Load/commit continues from the table: {1,2,3,4} commits at frame end.
        run_to(FRM - 1);
        step(1'b0, 1'b0, 20'h0);
        check("commit_frame", 32'(frame_o), 32'd1);
        check("commit_pend", 32'(pending_o), 32'd0);
        step(1'b0, 1'b0, 20'h0);
        check("dead_dig", 32'(dig_o), 32'd0);
        step(1'b0, 1'b0, 20'h0);
        check("d0_seg", 32'(seg_o), 32'h33);
        check("d0_dig", 32'(dig_o), 32'b0001);
        run_to(FRM + 3 * RD + 1);
        step(1'b0, 1'b0, 20'h0);
        check("d3_seg", 32'(seg_o), 32'h30);
        check("d3_dig", 32'(dig_o), 32'b1000);

        // Double load: only the latest value is ever shown.
        do_reset();
        step(1'b0, 1'b1, pack4(5'h1, 5'h2, 5'h3, 5'h4));
        run_to(8);
        step(1'b0, 1'b1, pack4(5'h8, 5'h8, 5'h8, 5'h8));
        run_to(FRM);
        for (int k = FRM; k < 2 * FRM; k++) begin
            step(1'b0, 1'b0, 20'h0);
            if (k % RD != 0) check("dbl_seg", 32'(seg_o), 32'h7F);
        end

        // Load exactly on the commit cycle with nothing pending.
        do_reset();
        run_to(FRM - 1);
        step(1'b0, 1'b1, pack4(5'h11, 5'h11, 5'h11, 5'h11));
        check("cc_frame", 32'(frame_o), 32'd1);
        check("cc_pend", 32'(pending_o), 32'd1);
        for (int k = FRM; k < 2 * FRM; k++) begin
            step(1'b0, 1'b0, 20'h0);
            if (k % RD != 0) check("cc_blank", 32'(seg_o), 32'h00);
        end
        for (int k = 2 * FRM; k < 3 * FRM; k++) begin
            step(1'b0, 1'b0, 20'h0);
            if (k % RD != 0) check("cc_minus", 32'(seg_o), 32'h01);
        end

        // Leading zeros {0,0,0,7}.
        do_reset();
        step(1'b0, 1'b1, pack4(5'h0, 5'h0, 5'h0, 5'h7));
        run_to(FRM);
        for (int k = FRM; k < 2 * FRM; k++) begin
            step(1'b0, 1'b0, 20'h0);
            if (k % RD != 0) begin
                if ((k / RD) % ND == 0) check("lz_d0", 32'(seg_o), 32'h70);
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
                else check("lz_hi", 32'(seg_o), 32'h00);
`else
                else check("lz_hi", 32'(seg_o), 32'h7E);
`endif
            end
        end

        // Mid-frame reset discards a pending load.
        do_reset();
        step(1'b0, 1'b1, pack4(5'h8, 5'h8, 5'h8, 5'h8));
        run_to(6);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 20'h0);
            check("mrst_seg", 32'(seg_o), 32'd0);
            check("mrst_dig", 32'(dig_o), 32'd0);
            check("mrst_pend", 32'(pending_o), 32'd0);
            check("mrst_frame", 32'(frame_o), 32'd0);
        end
        for (int k = 0; k < 2 * FRM; k++) begin
            step(1'b0, 1'b0, 20'h0);
            if (k % RD != 0) check("mrst_blank", 32'(seg_o), 32'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic r;
            logic ld;
            logic [19:0] d;
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < ND; k++) d[k*5 +: 5] = 5'($urandom_range(0, 31));
            step(r, ld, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
